line_fill_buffer: RTL

- Upstream stage of the 4:1 word-select mux.
- Fetches one 4-word (128-bit) line from memory as four 32-bit beats, assembling the beats into a 128-bit line register (`Line_Out`). `Line_Out` drives the mux 128-bit input directly.
- Also drives the mux select (`Word_Sel`) with the word offset of the requesting address.
- Sits between the memory beat interface and the word-select mux in the line-fetch path.

---
 rtl/line_fill_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/line_fill_buffer.sv
// rtl/line_fill_buffer.sv - four-beat line fill into a 128-bit register feeding the word-select mux
// Optional LINE_FILL_CRITICAL_WORD_FIRST_EN: wrap-order fetch from Addr[3:2] plus Crit_Valid pulse.
module line_fill_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    input  logic [ADDR_W-1:0]   Addr,
    output logic                Mem_Req,
    output logic [ADDR_W-1:0]   Mem_Addr,
    input  logic                Mem_Valid,
    input  logic [DATA_W-1:0]   Mem_Data,
    output logic [4*DATA_W-1:0] Line_Out,
    output logic [1:0]          Word_Sel,
    output logic                Line_Valid,
    input  logic                Line_Ack,
    output logic                Busy
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                Crit_Valid
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]          state;
    logic [ADDR_W-5:0]   base_q;
    logic [1:0]          idx_q;
    logic [1:0]          cnt_q;
    logic [1:0]          word_sel_q;
    logic [4*DATA_W-1:0] line_q;
    logic [1:0]          start_idx;
    logic                unused_addr_lsbs;

    // Byte-lane bits never matter: every beat is a whole word.
    assign unused_addr_lsbs = ^Addr[1:0];

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = Addr[3:2];
`else
    assign start_idx = 2'd0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            idx_q      <= 2'd0;
            cnt_q      <= 2'd0;
            word_sel_q <= 2'd0;
            line_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        base_q     <= Addr[ADDR_W-1:4];
                        word_sel_q <= Addr[3:2];
                        idx_q      <= start_idx;
                        cnt_q      <= 2'd0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (Mem_Valid) begin
                        line_q[idx_q*DATA_W +: DATA_W] <= Mem_Data;
                        idx_q <= idx_q + 2'd1;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (Line_Ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    // The critical word lands first, so the mux output is usable one cycle after it.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Crit_Valid <= 1'b0;
        end else begin
            Crit_Valid <= (state == FILL) && Mem_Valid && (cnt_q == 2'd0);
        end
    end
`endif

    assign Mem_Req    = (state == FILL);
    assign Mem_Addr   = (state == FILL) ? {base_q, idx_q, 2'b00} : '0;
    assign Line_Out   = line_q;
    assign Word_Sel   = word_sel_q;
    assign Line_Valid = (state == FULL);
    assign Busy       = (state != IDLE);

endmodule
